// File: rtl/balanca_pkg.sv
// -----------------------------------------------------------------------------
// balanca_pkg
// Definitions shared by the Balanca blocks: default datapath width, default
// number of centimos per euro, and the controller state encoding.
// -----------------------------------------------------------------------------
package balanca_pkg;

    localparam int LARGURA_DEF = 10;
    localparam int DIVISOR_DEF = 100;

    typedef logic [1:0] estado_t;

    localparam estado_t ST_IDLE   = 2'd0;
    localparam estado_t ST_DIVIDE = 2'd1;
    localparam estado_t ST_DONE   = 2'd2;

endpackage

// File: rtl/balanca_ctrl_divisor_seq.sv
// -----------------------------------------------------------------------------
// divisor_seq
// Sequential divider by repeated subtraction of a constant DIVISOR.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   start       load dividendo into the remainder and clear the quotient
//   passo       one division step is allowed this cycle
//   dividendo   value to divide (sampled on start)
//   done        combinational: a step was allowed and the remainder is
//               already below DIVISOR, so quociente/resto are final
//   quociente   running quotient
//   resto       running remainder
// -----------------------------------------------------------------------------
module divisor_seq
    import balanca_pkg::*;
#(
    parameter int LARGURA = LARGURA_DEF,
    parameter int DIVISOR = DIVISOR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               passo,
    input  logic [LARGURA-1:0] dividendo,
    output logic               done,
    output logic [LARGURA-1:0] quociente,
    output logic [LARGURA-1:0] resto
);

    localparam logic [LARGURA-1:0] DIV_V = LARGURA'(DIVISOR);

    logic [LARGURA-1:0] resto_q, resto_d;
    logic [LARGURA-1:0] quoc_q, quoc_d;
    logic               menor;

    assign menor = (resto_q < DIV_V);

    always_comb begin
        resto_d = resto_q;
        quoc_d  = quoc_q;
        if (start) begin
            resto_d = dividendo;
            quoc_d  = '0;
        end else if (passo && !menor) begin
            resto_d = resto_q - DIV_V;
            quoc_d  = quoc_q + LARGURA'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resto_q <= '0;
            quoc_q  <= '0;
        end else begin
            resto_q <= resto_d;
            quoc_q  <= quoc_d;
        end
    end

    assign done      = passo && menor;
    assign quociente = quoc_q;
    assign resto     = resto_q;

endmodule

// File: rtl/balanca_ctrl.sv
// -----------------------------------------------------------------------------
// balanca_ctrl
// Price accumulator with saturating total and a cents-to-euros converter.
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   item_valid/ready    item handshake; centimos is the item price
//   converter           start converting the running total (IDLE only)
//   limpar              clear total and overflow (IDLE only)
//   ocupado             high while the division runs
//   done                one-cycle pulse, conversion results valid
//   eurosinteiros       whole euros of the last conversion
//   eurosfracao         remaining cents of the last conversion
//   total               running total in cents (saturating)
//   overflow            sticky saturation flag
// -----------------------------------------------------------------------------
module balanca_ctrl
    import balanca_pkg::*;
#(
    parameter int LARGURA = LARGURA_DEF,
    parameter int DIVISOR = DIVISOR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               item_valid,
    output logic               item_ready,
    input  logic [LARGURA-1:0] centimos,
    input  logic               converter,
    input  logic               limpar,
    output logic               ocupado,
    output logic               done,
    output logic [LARGURA-1:0] eurosinteiros,
    output logic [LARGURA-1:0] eurosfracao,
    output logic [LARGURA-1:0] total,
    output logic               overflow
);

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] total_q, total_d;
    logic [LARGURA-1:0] ei_q, ei_d;
    logic [LARGURA-1:0] ef_q, ef_d;
    logic               overflow_q, overflow_d;

    logic               em_idle;
    logic               em_divide;
    logic               inicio;
    logic               aceita;
    logic [LARGURA:0]   soma;
    logic               div_fim;
    logic [LARGURA-1:0] div_quoc;
    logic [LARGURA-1:0] div_resto;

    assign em_idle   = (estado_q == ST_IDLE);
    assign em_divide = (estado_q == ST_DIVIDE);
    assign inicio    = em_idle && converter;
    // A conversion request masks the item handshake in the same cycle.
    assign item_ready = em_idle && !converter;
    assign aceita     = item_valid && item_ready;
    // One extra bit catches the carry that signals saturation.
    assign soma       = {1'b0, total_q} + {1'b0, centimos};

    divisor_seq #(
        .LARGURA (LARGURA),
        .DIVISOR (DIVISOR)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (inicio),
        .passo     (em_divide),
        .dividendo (total_q),
        .done      (div_fim),
        .quociente (div_quoc),
        .resto     (div_resto)
    );

    always_comb begin
        estado_d   = estado_q;
        total_d    = total_q;
        ei_d       = ei_q;
        ef_d       = ef_q;
        overflow_d = overflow_q;
        case (estado_q)
            ST_IDLE: begin
                if (converter) begin
                    estado_d = ST_DIVIDE;
                end
                // The divider samples the pre-clear total, so a clear in the
                // same cycle as a conversion still converts the old value.
                if (limpar) begin
                    total_d    = '0;
                    overflow_d = 1'b0;
                end else if (aceita) begin
                    if (soma[LARGURA]) begin
                        total_d    = '1;
                        overflow_d = 1'b1;
                    end else begin
                        total_d = soma[LARGURA-1:0];
                    end
                end
            end
            ST_DIVIDE: begin
                if (div_fim) begin
                    ei_d     = div_quoc;
                    ef_d     = div_resto;
                    estado_d = ST_DONE;
                end
            end
            ST_DONE: begin
                estado_d = ST_IDLE;
            end
            default: begin
                estado_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= ST_IDLE;
            total_q    <= '0;
            ei_q       <= '0;
            ef_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            total_q    <= total_d;
            ei_q       <= ei_d;
            ef_q       <= ef_d;
            overflow_q <= overflow_d;
        end
    end

    assign ocupado       = em_divide;
    assign done          = (estado_q == ST_DONE);
    assign eurosinteiros = ei_q;
    assign eurosfracao   = ef_q;
    assign total         = total_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_balanca_ctrl.sv
// -----------------------------------------------------------------------------
// tb_balanca_ctrl
// Directed bench for balanca_ctrl with a cycle-level behavioural model and
// literal expectations for each scenario.
// -----------------------------------------------------------------------------
module tb_balanca_ctrl;

    localparam int L    = 10;
    localparam int D    = 100;
    localparam int MAXV = (1 << L) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         item_valid = 1'b0;
    logic         converter = 1'b0;
    logic         limpar = 1'b0;
    logic [L-1:0] centimos = '0;
    logic         item_ready;
    logic         ocupado;
    logic         done;
    logic [L-1:0] eurosinteiros;
    logic [L-1:0] eurosfracao;
    logic [L-1:0] total;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    balanca_ctrl #(.LARGURA(L), .DIVISOR(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .item_valid    (item_valid),
        .item_ready    (item_ready),
        .centimos      (centimos),
        .converter     (converter),
        .limpar        (limpar),
        .ocupado       (ocupado),
        .done          (done),
        .eurosinteiros (eurosinteiros),
        .eurosfracao   (eurosfracao),
        .total         (total),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Conversion: after request, floor(N/D)+1 busy cycles, then one done
    // cycle with N/D and N%D.
    int m_total = 0;
    int m_ovf   = 0;
    int m_ei    = 0;
    int m_ef    = 0;
    int m_left  = 0;
    int m_done  = 0;
    int m_snap  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_total = 0; m_ovf = 0; m_ei = 0; m_ef = 0;
            m_left = 0; m_done = 0; m_snap = 0;
        end else if (m_done != 0) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_ei   = m_snap / D;
                m_ef   = m_snap % D;
                m_done = 1;
            end
        end else begin
            if (converter) begin
                m_snap = m_total;
                m_left = m_total / D + 1;
            end
            if (limpar) begin
                m_total = 0;
                m_ovf   = 0;
            end else if (item_valid && !converter) begin
                if (m_total + int'(centimos) > MAXV) begin
                    m_total = MAXV;
                    m_ovf   = 1;
                end else begin
                    m_total = m_total + int'(centimos);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("item_ready", item_ready, (m_left == 0 && m_done == 0 && !converter) ? 1 : 0);
            check("ocupado", ocupado, (m_left > 0) ? 1 : 0);
            check("done", done, m_done);
            check("total", total, m_total);
            check("overflow", overflow, m_ovf);
            check("eurosinteiros", eurosinteiros, m_ei);
            check("eurosfracao", eurosfracao, m_ef);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic add_item(input int c);
        item_valid = 1'b1;
        centimos   = L'(c);
        tick();
        item_valid = 1'b0;
        $display("item %0d -> total %0d overflow %0d", c, total, overflow);
    endtask

    task automatic clear_total();
        limpar = 1'b1;
        tick();
        limpar = 1'b0;
        $display("limpar -> total %0d overflow %0d", total, overflow);
    endtask

    // Returns at the negedge of the done cycle, having counted busy cycles.
    task automatic wait_done(output int ciclos);
        bit ok;
        ok = 1'b0;
        ciclos = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (ocupado) ciclos++;
        end
        if (!ok) check("done_timeout", 0, 1);
        $display("conversion: %0d divide cycles -> %0d euros %0d cents", ciclos, eurosinteiros, eurosfracao);
    endtask

    task automatic convert(output int ciclos);
        converter = 1'b1;
        tick();
        converter = 1'b0;
        wait_done(ciclos);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Reset and first cycle after release
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_item_ready", item_ready, 1);
        check("rst_total", total, 0);
        check("rst_ocupado", ocupado, 0);
        tick();

        // Scenario 1: single item 470
        add_item(470);
        check("s1_total", total, 470);
        convert(cyc);
        check("s1_cycles", cyc, 5);
        check("s1_ei", eurosinteiros, 4);
        check("s1_ef", eurosfracao, 70);
        tick();

        // Scenario 2: 250 + 199 + 1
        clear_total();
        add_item(250);
        add_item(199);
        add_item(1);
        check("s2_total", total, 450);
        convert(cyc);
        check("s2_ei", eurosinteiros, 4);
        check("s2_ef", eurosfracao, 50);
        tick();

        // Scenario 3: saturation
        clear_total();
        add_item(1000);
        check("s3_ovf_before", overflow, 0);
        add_item(100);
        check("s3_total", total, 1023);
        check("s3_ovf", overflow, 1);
        convert(cyc);
        check("s3_ei", eurosinteiros, 10);
        check("s3_ef", eurosfracao, 23);
        tick();
        clear_total();
        check("s3_clr_total", total, 0);
        check("s3_clr_ovf", overflow, 0);

        // Scenario 4: item and converter in the same cycle
        add_item(99);
        item_valid = 1'b1;
        centimos   = L'(5);
        converter  = 1'b1;
        #1;
        check("s4_item_ready", item_ready, 0);
        tick();
        item_valid = 1'b0;
        converter  = 1'b0;
        wait_done(cyc);
        check("s4_ei", eurosinteiros, 0);
        check("s4_ef", eurosfracao, 99);
        check("s4_total", total, 99);
        tick();

        // Scenario 5: reset in the middle of a conversion of 900
        clear_total();
        add_item(900);
        converter = 1'b1;
        tick();
        converter = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-divide -> total %0d ocupado %0d done %0d", total, ocupado, done);
        check("s5_total", total, 0);
        check("s5_ocupado", ocupado, 0);
        check("s5_done", done, 0);
        check("s5_ei", eurosinteiros, 0);
        check("s5_ef", eurosfracao, 0);
        check("s5_ovf", overflow, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("s5_item_ready", item_ready, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("s5_no_done", done, 0);
        end
        tick();

        // Scenario 6: convert a zero total
        convert(cyc);
        check("s6_cycles", cyc, 1);
        check("s6_ei", eurosinteiros, 0);
        check("s6_ef", eurosfracao, 0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
